dodge_game_core: RTL and testbench
==================================

DODGE_GAME_CORE -- requirements
Module: dodge_game_core

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640: playfield width in pixels.
REQ-002 SHALL have parameter PLAYER_W, default 10: player icon width in pixels.
REQ-003 SHALL have parameter STEP, default 5: pixels moved per frame tick.
REQ-004 SHALL have parameter X_W, default 10: player_x width.
REQ-005 SHALL have parameter SCORE_W, default 10: score and high_score width.
REQ-006 SHALL have parameter HOLD_FRAMES, default 120: frame ticks spent in DEAD or NEWHS.
REQ-007 SHALL have port ClkPort  input  1  system clock; all logic on its rising edge.
REQ-008 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port frame_tick  input  1  one-ClkPort-cycle pulse per video frame; all game updates qualified by it.
REQ-010 SHALL have ports btn_start, btn_left, btn_right  input  1 each  level button inputs, synchronous to ClkPort.
REQ-011 SHALL have port collision  input  1  obstacle hit, sampled on frame_tick.
REQ-012 SHALL have port player_x  output  X_W  left edge of player icon.
REQ-013 SHALL have ports score, high_score  output  SCORE_W each.
REQ-014 SHALL have port state  output  2  encoding INIT=0, PLAY=1, NEWHS=2, DEAD=3.

Function
REQ-015 SHALL leave all registers unchanged on cycles with frame_tick=0.
REQ-016 SHALL register btn_start on each frame_tick; "start" means btn_start=1 on this tick and 0 on the previous tick.
REQ-017 INIT: SHALL hold player_x=(SCREEN_W-PLAYER_W)/2 and score=0; on start go to PLAY.
REQ-018 PLAY, collision=0: score SHALL increment by 1, saturating at 2^SCORE_W-1.
REQ-019 PLAY, collision=0: right alone SHALL add STEP, left alone SHALL subtract STEP, both or neither SHALL hold.
REQ-020 SHALL clamp movement: right gives min(x+STEP, SCREEN_W-PLAYER_W); left gives 0 if x<STEP; no wrap-around.
REQ-021 PLAY, collision=1: player_x and score SHALL freeze; if score>high_score go to NEWHS and load high_score<=score on the same tick, else go to DEAD (score=high_score goes to DEAD).
REQ-022 NEWHS/DEAD: SHALL count HOLD_FRAMES frame ticks, then go to INIT; buttons and collision ignored.
REQ-023 Hold counter SHALL clear on entry to NEWHS/DEAD.
REQ-024 start edge registered during hold SHALL NOT start a game; a fresh edge is needed in INIT.
REQ-025 Unreachable state encodings SHALL recover to INIT on the next frame_tick.
REQ-026 Outputs SHALL be registered: zero combinational paths from inputs to outputs.

Reset
REQ-027 On reset: state=INIT, player_x=(SCREEN_W-PLAYER_W)/2, score=0, high_score=0, hold counter=0, start history=0.
REQ-028 Reset mid-game SHALL take effect immediately, asynchronously; high_score is cleared only by reset.

Configuration
REQ-029 Macro DODGE_SPEEDUP_EN: when defined, movement step SHALL be 2*STEP while score>=256 (clamping per REQ-020 with 2*STEP).
REQ-030 Without DODGE_SPEEDUP_EN, step SHALL be STEP at all scores.

Verification
REQ-031 Reset, then start edge on a tick -> state=PLAY; next tick with btn_right -> player_x=320, score=1.
REQ-032 PLAY, player_x=633, btn_right for 3 ticks -> player_x=630 each tick; player_x=3 with btn_left -> 0, stays 0.
REQ-033 PLAY score=40, high_score=0, collision -> state=NEWHS, high_score=40; after 120 ticks -> INIT, score=0.
REQ-034 PLAY score=40, high_score=40, collision -> DEAD, high_score stays 40; btn_start held throughout -> stays INIT until released and re-pressed.
REQ-035 Both buttons held -> player_x unchanged; reset asserted mid-PLAY between ticks -> all REQ-027 values at once.
REQ-036 With DODGE_SPEEDUP_EN, score=256, btn_left from x=315 -> 305; without it -> 310.

Source files
------------

// File: rtl/dodge_game_core.sv
// Dodge game core: player position, score, high score and game FSM, all updated on frame_tick.
// Ports: ClkPort/reset (async, active-high), frame_tick, btn_start/left/right, collision in;
//        player_x, score, high_score, state (INIT=0 PLAY=1 NEWHS=2 DEAD=3) out, all registered.
// Option: define DODGE_SPEEDUP_EN to double the movement step once score reaches 256.
module dodge_game_core #(
    parameter int SCREEN_W    = 640,
    parameter int PLAYER_W    = 10,
    parameter int STEP        = 5,
    parameter int X_W         = 10,
    parameter int SCORE_W     = 10,
    parameter int HOLD_FRAMES = 120
) (
    input  logic               ClkPort,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               collision,
    output logic [X_W-1:0]     player_x,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_PLAY  = 2'd1,
        S_NEWHS = 2'd2,
        S_DEAD  = 2'd3
    } state_t;

    localparam int HC_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [X_W-1:0]     X_MAX     = X_W'(SCREEN_W - PLAYER_W);
    localparam logic [X_W-1:0]     X_MID     = X_W'((SCREEN_W - PLAYER_W) / 2);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [HC_W-1:0]    HOLD_LAST = HC_W'(HOLD_FRAMES - 1);

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] hs_q, hs_d;
    logic [HC_W-1:0]    hold_q, hold_d;
    logic               start_q, start_d;

    logic               start_edge;
    logic [X_W:0]       step;
    logic [X_W:0]       x_wide;
    logic [X_W:0]       x_sum;
    logic [X_W:0]       x_diff;

    assign start_edge = btn_start & ~start_q;
    assign x_wide     = {1'b0, x_q};

`ifdef DODGE_SPEEDUP_EN
    assign step = (32'(score_q) >= 32'd256) ? (X_W+1)'(2 * STEP)
                                             : (X_W+1)'(STEP);
`else
    assign step = (X_W+1)'(STEP);
`endif

    // Widened by one bit so the right-edge clamp sees overflow instead of wrapping.
    assign x_sum  = x_wide + step;
    assign x_diff = x_wide - step;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        score_d = score_q;
        hs_d    = hs_q;
        hold_d  = hold_q;
        start_d = start_q;
        if (frame_tick) begin
            start_d = btn_start;
            case (state_q)
                S_INIT: begin
                    x_d     = X_MID;
                    score_d = '0;
                    if (start_edge) begin
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (collision) begin
                        hold_d = '0;
                        if (score_q > hs_q) begin
                            state_d = S_NEWHS;
                            hs_d    = score_q;
                        end else begin
                            state_d = S_DEAD;
                        end
                    end else begin
                        if (score_q != SCORE_MAX) begin
                            score_d = score_q + 1'b1;
                        end
                        if (btn_right && !btn_left) begin
                            x_d = (x_sum > {1'b0, X_MAX}) ? X_MAX
                                                         : x_sum[X_W-1:0];
                        end else if (btn_left && !btn_right) begin
                            x_d = (x_wide < step) ? '0 : x_diff[X_W-1:0];
                        end
                    end
                end
                S_NEWHS, S_DEAD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = S_INIT;
                        hold_d  = '0;
                        x_d     = X_MID;
                        score_d = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_INIT;
                    hold_d  = '0;
                    x_d     = X_MID;
                    score_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge ClkPort or posedge reset) begin
        if (reset) begin
            state_q <= S_INIT;
            x_q     <= X_MID;
            score_q <= '0;
            hs_q    <= '0;
            hold_q  <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            score_q <= score_d;
            hs_q    <= hs_d;
            hold_q  <= hold_d;
            start_q <= start_d;
        end
    end

    assign player_x   = x_q;
    assign score      = score_q;
    assign high_score = hs_q;
    assign state      = state_q;

endmodule

// File: tb/tb_dodge_game_core.sv
// Directed testbench for dodge_game_core (default parameters).
// Honours DODGE_SPEEDUP_EN for the fast-step expectation.
`timescale 1ns/1ps
module tb_dodge_game_core;

    logic       ClkPort = 1'b0;
    logic       reset   = 1'b1;
    logic       frame_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_left  = 1'b0;
    logic       btn_right = 1'b0;
    logic       collision = 1'b0;
    logic [9:0] player_x;
    logic [9:0] score;
    logic [9:0] high_score;
    logic [1:0] state;

    int n_chk = 0;
    int n_err = 0;

    dodge_game_core dut (
        .ClkPort    (ClkPort),
        .reset      (reset),
        .frame_tick (frame_tick),
        .btn_start  (btn_start),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .collision  (collision),
        .player_x   (player_x),
        .score      (score),
        .high_score (high_score),
        .state      (state)
    );

    always #5 ClkPort = ~ClkPort;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int x,
                           input int s, input int hs);
        chk({tag, ".state"}, 32'(state), st);
        chk({tag, ".x"}, 32'(player_x), x);
        chk({tag, ".score"}, 32'(score), s);
        chk({tag, ".hs"}, 32'(high_score), hs);
    endtask

    task automatic set_in(input logic s, input logic l, input logic r,
                          input logic c);
        btn_start = s;
        btn_left  = l;
        btn_right = r;
        collision = c;
    endtask

    // One frame tick followed by an idle cycle, ending on a negedge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge ClkPort);
            frame_tick = 1'b1;
            @(negedge ClkPort);
            frame_tick = 1'b0;
            @(negedge ClkPort);
        end
    endtask

    task automatic do_reset();
        @(negedge ClkPort);
        reset = 1'b1;
        @(negedge ClkPort);
        reset = 1'b0;
    endtask

    int exp_fast;

    initial begin
`ifdef DODGE_SPEEDUP_EN
        exp_fast = 305;
`else
        exp_fast = 310;
`endif
        repeat (2) @(negedge ClkPort);
        chk_all("reset", 0, 315, 0, 0);
        reset = 1'b0;

        // Idle cycles without frame_tick change nothing, even with inputs active.
        set_in(1, 0, 1, 0);
        repeat (4) @(negedge ClkPort);
        chk_all("no_tick", 0, 315, 0, 0);

        tick(1);
        chk_all("start", 1, 315, 0, 0);
        set_in(0, 0, 1, 0);
        tick(1);
        chk_all("first_right", 1, 320, 1, 0);

        tick(62);
        chk_all("right_edge", 1, 630, 63, 0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("right_clamp", 32'(player_x), 630);
        end

        set_in(0, 1, 0, 0);
        tick(63);
        chk_all("left_mid", 1, 315, 129, 0);
        set_in(0, 0, 0, 0);
        tick(127);
        chk_all("idle_256", 1, 315, 256, 0);
        set_in(0, 1, 0, 0);
        tick(1);
        chk_all("left_fast", 1, exp_fast, 257, 0);

        tick(62);
        chk_all("left_zero", 1, 0, 319, 0);
        tick(2);
        chk_all("left_clamp", 1, 0, 321, 0);
        set_in(0, 1, 1, 0);
        tick(1);
        chk_all("both", 1, 0, 322, 0);
        set_in(0, 1, 1, 1);
        tick(1);
        chk_all("hit_newhs", 2, 0, 322, 322);

        // Fresh game for the score-40 scenarios.
        set_in(0, 0, 0, 0);
        do_reset();
        chk_all("reset2", 0, 315, 0, 0);
        set_in(1, 0, 0, 0);
        tick(1);
        set_in(0, 0, 0, 0);
        tick(40);
        chk_all("score40", 1, 315, 40, 0);
        set_in(0, 0, 0, 1);
        tick(1);
        chk_all("newhs40", 2, 315, 40, 40);
        set_in(0, 0, 0, 0);
        tick(119);
        chk_all("newhs_hold", 2, 315, 40, 40);
        tick(1);
        chk_all("newhs_exit", 0, 315, 0, 40);

        set_in(1, 0, 0, 0);
        tick(1);
        chk("restart", 32'(state), 1);
        set_in(0, 0, 0, 0);
        tick(40);
        set_in(1, 1, 0, 1);
        tick(1);
        chk_all("dead_eq", 3, 315, 40, 40);
        tick(119);
        chk_all("dead_hold", 3, 315, 40, 40);
        tick(1);
        chk_all("dead_exit", 0, 315, 0, 40);
        tick(3);
        chk("held_start", 32'(state), 0);
        set_in(0, 0, 0, 0);
        tick(1);
        chk("released", 32'(state), 0);
        set_in(1, 0, 0, 0);
        tick(1);
        chk("repress", 32'(state), 1);

        set_in(0, 0, 0, 0);
        tick(1030);
        chk_all("saturate", 1, 315, 1023, 40);

        // Asynchronous reset between ticks.
        set_in(0, 1, 0, 0);
        tick(1);
        #2 reset = 1'b1;
        #1;
        chk_all("async_rst", 0, 315, 0, 0);
        @(negedge ClkPort);
        reset = 1'b0;
        tick(1);
        chk_all("after_rst", 0, 315, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
